// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, mstatus fields, privilege/cause codes and FSM states
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int unsigned CAUSE_ILLEGAL_INSN = 2;
    localparam int unsigned CAUSE_BREAKPOINT   = 3;
    localparam int unsigned CAUSE_ECALL_U      = 8;
    localparam int unsigned CAUSE_ECALL_M      = 11;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDIRECT,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/csr_trap_unit_if.sv
// rtl/csr_trap_unit_if.sv - commit, CSR access and fetch-redirect signals between pipeline and trap unit
interface csr_trap_unit_if #(parameter int DATA_WIDTH = 32);
    logic                  commit_valid;
    logic [DATA_WIDTH-1:0] commit_pc;
    logic                  exception_valid;
    logic [DATA_WIDTH-1:0] exception_cause;
    logic                  is_mret;
    logic                  is_csr;
    logic [2:0]            csr_op;
    logic [11:0]           csr_addr;
    logic [DATA_WIDTH-1:0] csr_src;
    logic [4:0]            rs1_idx;
    logic [1:0]            cur_priv;
    logic [DATA_WIDTH-1:0] csr_rdata;
    logic [DATA_WIDTH-1:0] mstatus;
    logic                  trap_taken;
    logic                  mret_taken;
    logic                  redirect_valid;
    logic                  redirect_ready;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  busy;
    logic                  flush;

    modport master (
        output commit_valid, commit_pc, exception_valid, exception_cause, is_mret, is_csr,
               csr_op, csr_addr, csr_src, rs1_idx, cur_priv, redirect_ready,
        input  csr_rdata, mstatus, trap_taken, mret_taken, redirect_valid, redirect_pc, busy, flush
    );

    modport slave (
        input  commit_valid, commit_pc, exception_valid, exception_cause, is_mret, is_csr,
               csr_op, csr_addr, csr_src, rs1_idx, cur_priv, redirect_ready,
        output csr_rdata, mstatus, trap_taken, mret_taken, redirect_valid, redirect_pc, busy, flush
    );
endinterface

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR storage, read mux and read-modify-write datapath
module csr_regfile
    import csr_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csr_en_i,
    input  csr_op_e               csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic [4:0]            rs1_idx_i,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic [DATA_WIDTH-1:0] trap_cause_i,
    input  logic [1:0]            trap_priv_i,
    input  logic                  mret_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [DATA_WIDTH-1:0] mstatus_o,
    output logic [DATA_WIDTH-1:0] mtvec_o,
    output logic [DATA_WIDTH-1:0] mepc_o
);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    logic                  mie_q, mpie_q;
    logic [1:0]            mpp_q;
    logic [DATA_WIDTH-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [DATA_WIDTH-1:0] mstatus, rdata, wdata;
    logic                  we;

    always_comb begin
        mstatus = '0;
        mstatus[MSTATUS_MIE]  = mie_q;
        mstatus[MSTATUS_MPIE] = mpie_q;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
    end

    always_comb begin
        rdata = '0;
        case (csr_addr_i)
            CSR_MSTATUS:  rdata = mstatus;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MTVAL:    rdata = mtval_q;
            default:      rdata = '0;
        endcase
    end

    // Set/clear with rs1=x0 (or zimm=0) is a pure read and must not disturb the CSR.
    always_comb begin
        wdata = rdata;
        case (csr_op_i)
            CSR_OP_WRITE: wdata = operand_i;
            CSR_OP_SET:   wdata = rdata | operand_i;
            CSR_OP_CLEAR: wdata = rdata & ~operand_i;
            default:      wdata = rdata;
        endcase
        we = csr_en_i && ((csr_op_i == CSR_OP_WRITE) ||
                          ((csr_op_i != CSR_OP_NONE) && (rs1_idx_i != 5'd0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mpp_q      <= PRIV_M;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_i) begin
            mepc_q   <= trap_pc_i & ALIGN_MASK;
            mcause_q <= trap_cause_i;
            mtval_q  <= '0;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
            mpp_q    <= trap_priv_i;
        end else if (mret_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
            mpp_q  <= PRIV_U;
        end else if (we) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie_q  <= wdata[MSTATUS_MIE];
                    mpie_q <= wdata[MSTATUS_MPIE];
                    mpp_q  <= wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                end
                CSR_MTVEC:    mtvec_q    <= wdata & ALIGN_MASK;
                CSR_MSCRATCH: mscratch_q <= wdata;
                CSR_MEPC:     mepc_q     <= wdata & ALIGN_MASK;
                CSR_MCAUSE:   mcause_q   <= wdata;
                CSR_MTVAL:    mtval_q    <= wdata;
                default: ;
            endcase
        end
    end

    assign rdata_o   = rdata;
    assign mstatus_o = mstatus;
    assign mtvec_o   = mtvec_q;
    assign mepc_o    = mepc_q;
endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - commit arbitration, trap/mret sequencing and fetch-redirect FSM
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    csr_trap_unit_if.slave bus
);
    state_e                state_q;
    logic                  redirect_valid_q, flush_q, busy_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;
    logic [DATA_WIDTH-1:0] mtvec, mepc, operand;
    logic                  accept, trap, mret, csr_en;

    // Priority on one commit: exception, then mret, then CSR access.
    assign accept  = bus.commit_valid && (state_q == ST_IDLE);
    assign trap    = accept && bus.exception_valid;
    assign mret    = accept && !bus.exception_valid && bus.is_mret;
    assign csr_en  = accept && !bus.exception_valid && !bus.is_mret && bus.is_csr;
    assign operand = bus.csr_op[2] ? DATA_WIDTH'(bus.rs1_idx) : bus.csr_src;

    csr_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_en_i     (csr_en),
        .csr_op_i     (csr_op_e'(bus.csr_op[1:0])),
        .csr_addr_i   (bus.csr_addr),
        .operand_i    (operand),
        .rs1_idx_i    (bus.rs1_idx),
        .trap_i       (trap),
        .trap_pc_i    (bus.commit_pc),
        .trap_cause_i (bus.exception_cause),
        .trap_priv_i  (bus.cur_priv),
        .mret_i       (mret),
        .rdata_o      (bus.csr_rdata),
        .mstatus_o    (bus.mstatus),
        .mtvec_o      (mtvec),
        .mepc_o       (mepc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trap || mret) begin
                        state_q          <= ST_REDIRECT;
                        redirect_valid_q <= 1'b1;
                        busy_q           <= 1'b1;
                        redirect_pc_q    <= trap ? mtvec : mepc;
                    end
                end
                ST_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state_q          <= ST_FLUSH;
                        redirect_valid_q <= 1'b0;
                        flush_q          <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_IDLE;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q          <= ST_IDLE;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    busy_q           <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trap_taken     = trap;
    assign bus.mret_taken     = mret;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = flush_q;
    assign bus.busy           = busy_q;
endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, as the CSR and PC width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port commit_valid, input, 1 bit: the instruction at commit is valid.
REQ-005 The block SHALL have port commit_pc, input, DATA_WIDTH bits: the PC of the committing instruction.
REQ-006 The block SHALL have ports exception_valid (input, 1 bit) and exception_cause (input, DATA_WIDTH bits): the trap request and its cause code from decode.
REQ-007 The block SHALL have ports is_mret (input, 1), is_csr (input, 1) and csr_op (input, 3): the committing instruction class and its funct3.
REQ-008 The block SHALL have ports csr_addr (input, 12), csr_src (input, DATA_WIDTH) and rs1_idx (input, 5): the CSR address, the rs1 value or zero-extended zimm, and the rs1/zimm field.
REQ-009 The block SHALL have port cur_priv, input, 2 bits: the current privilege level.
REQ-010 The block SHALL have port csr_rdata, output, DATA_WIDTH bits: the old CSR value, which the pipeline writes to rd.
REQ-011 The block SHALL have port mstatus, output, DATA_WIDTH bits: the live mstatus register.
REQ-012 The block SHALL have ports trap_taken (output, 1) and mret_taken (output, 1): single-cycle acceptance pulses.
REQ-013 The block SHALL have ports redirect_valid (output, 1), redirect_ready (input, 1) and redirect_pc (output, DATA_WIDTH): the fetch redirect handshake.
REQ-014 The block SHALL have ports busy (output, 1), which tells upstream to hold commit, and flush (output, 1), which is a one-cycle pipeline flush.

Function
REQ-015 The implemented CSRs SHALL be mstatus 0x300 (MIE bit 3, MPIE bit 7, MPP bits 12:11; all other bits read 0), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342 and mtval 0x343.
REQ-016 The FSM SHALL have exactly three states: IDLE, REDIRECT and FLUSH.
REQ-017 A commit SHALL be accepted only when commit_valid=1 and the state is IDLE; commits in any other state SHALL be ignored, because busy=1 there.
REQ-018 On an accepted commit with exception_valid=1, trap_taken SHALL be 1 combinationally in that cycle, and at the next edge: mepc<=commit_pc with bits 1:0 cleared, mcause<=exception_cause, mtval<=0, MPIE<=MIE, MIE<=0, MPP<=cur_priv, and state<=REDIRECT with redirect_pc=mtvec.
REQ-019 On an accepted commit with is_mret=1 and exception_valid=0, mret_taken SHALL be 1 in that cycle, and at the next edge: MIE<=MPIE, MPIE<=1, MPP<=2'b00, and state<=REDIRECT with redirect_pc=mepc.
REQ-020 The priority on a single commit SHALL be exception_valid, then is_mret, then is_csr.
REQ-021 On an accepted commit with is_csr=1 (and neither higher-priority request), csr_rdata SHALL be the combinational pre-write value at csr_addr, and the write SHALL occur at the next edge; the state SHALL remain IDLE.
REQ-022 CSR operations SHALL decode as csr_op[1:0]=01 write, 10 set (old|src) and 11 clear (old&~src), with csr_op[2] selecting zimm; set and clear SHALL perform no write when rs1_idx=0.
REQ-023 Writes to mtvec and mepc SHALL force bits 1:0 to 0; mtvec SHALL support direct mode only.
REQ-024 Reads of unimplemented addresses SHALL return 0, and writes to them SHALL be ignored.
REQ-025 In REDIRECT, redirect_valid=1 and redirect_pc SHALL be held stable until redirect_ready=1; on that handshake edge the state SHALL go to FLUSH.
REQ-026 In FLUSH, flush=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-027 busy SHALL equal 1 whenever the state is not IDLE.
REQ-028 If redirect_valid=1 and redirect_ready=1 in the same cycle the REDIRECT state is entered, the transfer SHALL complete, and the minimum trap-to-IDLE latency SHALL be 3 cycles.
REQ-029 trap_taken and mret_taken SHALL never both be 1 in the same cycle.

Reset
REQ-030 While rst_n=0, the block SHALL be in state IDLE and all CSRs SHALL be 0 except mstatus.MPP=2'b11; redirect_valid, flush, busy, trap_taken and mret_taken SHALL all be 0.
REQ-031 Reset asserted in REDIRECT or FLUSH SHALL abort the sequence immediately, with no redirect completing.

Structure
REQ-032 The package csr_pkg SHALL hold the CSR address constants, the mstatus bit positions, the privilege encodings, the cause codes (2, 3, 8, 11) and the FSM state enum.
REQ-033 The register file and read mux SHALL be the single sub-module csr_regfile, with the FSM and trap sequencing in csr_trap_unit.

Verification
REQ-034 Scenario ECALL from U-mode: commit_pc=0x100, cause=8, cur_priv=00, mtvec=0x200 -> trap_taken pulse; mepc=0x100, mcause=8, MPP=00, MIE=0; redirect_pc=0x200; flush one cycle after the handshake.
REQ-035 Scenario MRET: MPIE=1, mepc=0x104 -> MIE=1, MPP=00, redirect_pc=0x104.
REQ-036 Scenario CSR ops: CSRRW mscratch 0xDEADBEEF, then CSRRS rs1_idx=0 -> csr_rdata=0xDEADBEEF with no write; then CSRRC src=0xF -> mscratch=0xDEADBEE0.
REQ-037 Scenario stalled redirect: redirect_ready held 0 for 5 cycles -> redirect_pc stable, busy=1, and commits presented meanwhile are ignored.
REQ-038 Scenario reset during REDIRECT -> redirect_valid=0 immediately and MPP=11.
REQ-039 Scenario mtvec write 0x203 -> readback 0x200.
